// File: rtl/bcp_clause_engine.sv
// Boolean constraint propagation clause evaluator.
// Accepts one clause at a time, scans its literals LANES per cycle, classifies
// the clause as SAT / UNIT / CONFLICT / UNRESOLVED and queues the result in a
// small FIFO. Per-thread flush discards both queued and in-flight work.
module bcp_clause_engine #(
    parameter int LIT_NUM  = 4,
    parameter int LANES    = 1,
    parameter int VAR_W    = 12,
    parameter int THREAD_W = 1,
    parameter int ID_W     = 16,
    parameter int Q_DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [THREAD_W-1:0]          in_thread,
    input  logic [ID_W-1:0]              in_clause_id,
    input  logic [LIT_NUM-1:0]           in_lit_en,
    input  logic [LIT_NUM*(VAR_W+1)-1:0] in_lits,
    input  logic [LIT_NUM*2-1:0]         in_assign,
    input  logic                         flush_valid,
    input  logic [THREAD_W-1:0]          flush_thread,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_status,
    output logic [VAR_W:0]               out_lit,
    output logic [THREAD_W-1:0]          out_thread,
    output logic [ID_W-1:0]              out_clause_id,
    output logic [15:0]                  stat_unit_cnt,
    output logic [15:0]                  stat_conflict_cnt
);
    localparam int SW     = VAR_W + 1;
    localparam int CHUNKS = LIT_NUM / LANES;
    localparam int CW     = $clog2(CHUNKS + 1);
    localparam int PW     = $clog2(Q_DEPTH);
    localparam int OW     = PW + 1;

    localparam logic [1:0] ST_SAT   = 2'b00;
    localparam logic [1:0] ST_UNIT  = 2'b01;
    localparam logic [1:0] ST_CONF  = 2'b10;
    localparam logic [1:0] ST_UNRES = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, PUSH} state_t;

    state_t                 state_q;
    logic [CW-1:0]          chunk_q;
    logic [THREAD_W-1:0]    thread_q;
    logic [ID_W-1:0]        id_q;
    logic [LIT_NUM-1:0]     en_q;
    logic [LIT_NUM*SW-1:0]  lits_q;
    logic [LIT_NUM*2-1:0]   asg_q;
    logic                   true_q, true_d;
    logic [1:0]             ucnt_q, ucnt_d;
    logic [SW-1:0]          ulit_q, ulit_d;
    logic [15:0]            unit_cnt_q, conf_cnt_q;

    logic [1:0]             f_status_q [Q_DEPTH];
    logic [SW-1:0]          f_lit_q    [Q_DEPTH];
    logic [THREAD_W-1:0]    f_thread_q [Q_DEPTH];
    logic [ID_W-1:0]        f_id_q     [Q_DEPTH];
    logic                   f_live_q   [Q_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]          occ_q;

    logic       accept, accept_drop, flush_cur, push, pop;
    logic [1:0] cls_status;
    logic [SW-1:0] cls_lit;

    assign in_ready    = RST && (state_q == IDLE) && (occ_q < OW'(Q_DEPTH));
    assign accept      = in_valid && in_ready;
    assign accept_drop = flush_valid && (flush_thread == in_thread);
    assign flush_cur   = flush_valid && (flush_thread == thread_q);
    assign push        = (state_q == PUSH) && !flush_cur;
    assign pop         = (occ_q != '0) && (!f_live_q[rd_ptr_q] || out_ready);

    assign out_valid         = (occ_q != '0) && f_live_q[rd_ptr_q];
    assign out_status        = f_status_q[rd_ptr_q];
    assign out_lit           = f_lit_q[rd_ptr_q];
    assign out_thread        = f_thread_q[rd_ptr_q];
    assign out_clause_id     = f_id_q[rd_ptr_q];
    assign stat_unit_cnt     = unit_cnt_q;
    assign stat_conflict_cnt = conf_cnt_q;

    // Fold the current chunk's enabled slots into the running scan state, in slot order.
    always_comb begin
        true_d = true_q;
        ucnt_d = ucnt_q;
        ulit_d = ulit_q;
        for (int s = 0; s < LIT_NUM; s++) begin
            if ((s / LANES) == int'(chunk_q) && en_q[s]) begin
                if (asg_q[s*2 +: 2] == 2'b10) begin
                    true_d = 1'b1;
                end else if (asg_q[s*2 +: 2] != 2'b01) begin
                    // 00 and 11 both count as unassigned
                    if (ucnt_d == 2'd0) ulit_d = lits_q[s*SW +: SW];
                    if (ucnt_d != 2'd2) ucnt_d = ucnt_d + 2'd1;
                end
            end
        end
    end

    // Final classification from the registered scan state, used during PUSH.
    always_comb begin
        cls_lit = '0;
        if (true_q)              cls_status = ST_SAT;
        else if (ucnt_q == 2'd0) cls_status = ST_CONF;
        else if (ucnt_q == 2'd1) begin
            cls_status = ST_UNIT;
            cls_lit    = ulit_q;
        end
        else                     cls_status = ST_UNRES;
    end

    // Clause FSM: capture, chunked scan with early exit, push, and statistics.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            chunk_q    <= '0;
            thread_q   <= '0;
            id_q       <= '0;
            en_q       <= '0;
            lits_q     <= '0;
            asg_q      <= '0;
            true_q     <= 1'b0;
            ucnt_q     <= 2'd0;
            ulit_q     <= '0;
            unit_cnt_q <= '0;
            conf_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !accept_drop) begin
                        thread_q <= in_thread;
                        id_q     <= in_clause_id;
                        en_q     <= in_lit_en;
                        lits_q   <= in_lits;
                        asg_q    <= in_assign;
                        chunk_q  <= '0;
                        true_q   <= 1'b0;
                        ucnt_q   <= 2'd0;
                        ulit_q   <= '0;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (flush_cur) begin
                        state_q <= IDLE;
                    end else begin
                        true_q <= true_d;
                        ucnt_q <= ucnt_d;
                        ulit_q <= ulit_d;
                        if (true_d || ucnt_d == 2'd2 || chunk_q == CW'(CHUNKS - 1))
                            state_q <= PUSH;
                        else
                            chunk_q <= chunk_q + CW'(1);
                    end
                end
                PUSH: begin
                    state_q <= IDLE;
                    if (push && cls_status == ST_UNIT && unit_cnt_q != 16'hFFFF)
                        unit_cnt_q <= unit_cnt_q + 16'd1;
                    if (push && cls_status == ST_CONF && conf_cnt_q != 16'hFFFF)
                        conf_cnt_q <= conf_cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result FIFO: flush clears live bits, push appends, head pops on handshake or when dead.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                f_status_q[i] <= '0;
                f_lit_q[i]    <= '0;
                f_thread_q[i] <= '0;
                f_id_q[i]     <= '0;
                f_live_q[i]   <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (flush_valid) begin
                for (int i = 0; i < Q_DEPTH; i++) begin
                    if (f_thread_q[i] == flush_thread) f_live_q[i] <= 1'b0;
                end
            end
            if (push) begin
                f_status_q[wr_ptr_q] <= cls_status;
                f_lit_q[wr_ptr_q]    <= cls_lit;
                f_thread_q[wr_ptr_q] <= thread_q;
                f_id_q[wr_ptr_q]     <= id_q;
                f_live_q[wr_ptr_q]   <= 1'b1;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      occ_q <= occ_q + OW'(1);
            else if (!push && pop) occ_q <= occ_q - OW'(1);
        end
    end
endmodule

// File: tb/tb_bcp_clause_engine.sv
// Directed testbench for bcp_clause_engine with default parameters.
module tb_bcp_clause_engine;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:0]  in_thread = '0;
    logic [15:0] in_clause_id = '0;
    logic [3:0]  in_lit_en = '0;
    logic [51:0] in_lits = '0;
    logic [7:0]  in_assign = '0;
    logic        flush_valid = 1'b0;
    logic [0:0]  flush_thread = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_status;
    logic [12:0] out_lit;
    logic [0:0]  out_thread;
    logic [15:0] out_clause_id;
    logic [15:0] stat_unit_cnt;
    logic [15:0] stat_conflict_cnt;

    int checks = 0;
    int errors = 0;

    // slot3 .. slot0
    localparam logic [51:0] LITS = {13'h1123, 13'h0ABC, 13'h0005, 13'h1001};

    bcp_clause_engine dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_thread(in_thread), .in_clause_id(in_clause_id),
        .in_lit_en(in_lit_en), .in_lits(in_lits), .in_assign(in_assign),
        .flush_valid(flush_valid), .flush_thread(flush_thread),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_status(out_status), .out_lit(out_lit),
        .out_thread(out_thread), .out_clause_id(out_clause_id),
        .stat_unit_cnt(stat_unit_cnt), .stat_conflict_cnt(stat_conflict_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  en;
        logic [7:0]  asg;   // slot0 at [1:0]
        logic [1:0]  st;
        logic [12:0] lit;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Offer one clause and hold it until accepted (bounded); returns in cycle 1.
    task automatic send(input logic [0:0] th, input logic [15:0] id,
                        input logic [3:0] en, input logic [7:0] asg);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=0 expected=1 id=%0h", id);
        end else begin
            in_thread = th; in_clause_id = id; in_lit_en = en;
            in_lits = LITS; in_assign = asg; in_valid = 1'b1;
            @(posedge CLK); #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] ids [$];
        logic [0:0]  ths [$];
        int k, n, acc, seen;

        vecs[0] = '{4'b1111, 8'b01_01_00_01, 2'b01, 13'h0005, 6};
        vecs[1] = '{4'b1111, 8'b00_00_00_10, 2'b00, 13'h0000, 3};
        vecs[2] = '{4'b1111, 8'b01_01_00_00, 2'b11, 13'h0000, 4};
        vecs[3] = '{4'b1111, 8'b01_01_01_01, 2'b10, 13'h0000, 6};
        vecs[4] = '{4'b0000, 8'b00_00_00_00, 2'b10, 13'h0000, 6};
        vecs[5] = '{4'b1111, 8'b11_01_01_01, 2'b01, 13'h1123, 6};
        vecs[6] = '{4'b1110, 8'b01_00_01_10, 2'b01, 13'h0ABC, 6};
        vecs[7] = '{4'b1111, 8'b10_01_01_00, 2'b00, 13'h0000, 6};
        vecs[8] = '{4'b1111, 8'b00_00_10_01, 2'b00, 13'h0000, 4};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_fields", {14'd0, out_status, out_lit, out_thread, 2'd0}, 32'd0);
        chk("rst_out_id", 32'(out_clause_id), 32'd0);
        chk("rst_counters", {stat_unit_cnt, stat_conflict_cnt}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;

        // Table-driven single clauses, out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(1'(i % 2), 16'h0100 + 16'(i), vecs[i].en, vecs[i].asg);
            k = 1;
            while (!out_valid && k < 20) begin
                @(posedge CLK); #1; k++;
            end
            chk($sformatf("v%0d_status", i), 32'(out_status), 32'(vecs[i].st));
            chk($sformatf("v%0d_lit", i), 32'(out_lit), 32'(vecs[i].lit));
            chk($sformatf("v%0d_latency", i), 32'(k), 32'(vecs[i].lat));
            chk($sformatf("v%0d_id", i), 32'(out_clause_id), 32'h0100 + 32'(i));
            chk($sformatf("v%0d_thread", i), 32'(out_thread), 32'(i % 2));
            @(posedge CLK); #1;
        end
        chk("unit_cnt_after_table", 32'(stat_unit_cnt), 32'd3);
        chk("conflict_cnt_after_table", 32'(stat_conflict_cnt), 32'd2);

        // Backpressure: four results fill the queue, the fifth waits
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 16'h0200 + 16'(i), 4'b1111, 8'b00_00_00_10);
        repeat (4) @(posedge CLK);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head_id", 32'(out_clause_id), 32'h0200);
        in_thread = 1'b0; in_clause_id = 16'h0204; in_lit_en = 4'b1111;
        in_lits = LITS; in_assign = 8'b00_00_00_10; in_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("stall_head_id", 32'(out_clause_id), 32'h0200);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        ids.delete();
        n = 0;
        while (ids.size() < 5 && n < 60) begin
            if (out_valid) ids.push_back(out_clause_id);
            acc = int'(in_valid && in_ready);
            @(posedge CLK); #1; n++;
            if (acc != 0) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_result_count", 32'(ids.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp_order_%0d", i), (i < ids.size()) ? 32'(ids[i]) : 32'hDEAD, 32'h0200 + 32'(i));

        // Flush thread 1: queued thread-1 result and thread-1 clause in scan are dropped
        out_ready = 1'b0;
        send(1'b0, 16'h0300, 4'b1111, 8'b00_00_00_10);   // SAT
        send(1'b1, 16'h0301, 4'b1111, 8'b00_00_00_10);   // SAT
        send(1'b0, 16'h0302, 4'b1111, 8'b01_01_01_01);   // CONFLICT
        repeat (6) @(posedge CLK);
        #1;
        send(1'b1, 16'h0303, 4'b1111, 8'b01_01_00_01);   // UNIT, still scanning
        flush_valid = 1'b1; flush_thread = 1'b1;
        @(posedge CLK); #1;
        flush_valid = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("flush_fsm_idle_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        ids.delete(); ths.delete();
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ids.push_back(out_clause_id);
                ths.push_back(out_thread);
            end
            @(posedge CLK); #1;
        end
        chk("flush_result_count", 32'(ids.size()), 32'd2);
        chk("flush_first_id", (ids.size() > 0) ? 32'(ids[0]) : 32'hDEAD, 32'h0300);
        chk("flush_second_id", (ids.size() > 1) ? 32'(ids[1]) : 32'hDEAD, 32'h0302);
        chk("flush_threads", (ths.size() > 1) ? 32'({ths[0], ths[1]}) : 32'hDEAD, 32'd0);
        chk("flush_unit_cnt", 32'(stat_unit_cnt), 32'd3);
        chk("flush_conflict_cnt", 32'(stat_conflict_cnt), 32'd3);

        // Reset during scan discards the clause
        send(1'b0, 16'h0400, 4'b1111, 8'b01_01_00_01);
        RST = 1'b0;
        #1;
        chk("midscan_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (out_valid) seen = 1;
        end
        chk("midscan_rst_no_result", 32'(seen), 32'd0);
        chk("midscan_rst_counters", {stat_unit_cnt, stat_conflict_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
